// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator and its LFSR.
// Mode/state encodings, LFSR polynomial, and the single-step LFSR function.
package axis_pkt_gen_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    localparam int LFSR_W = 32;

    // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1 (bit = exponent - 1).
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/axis_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and advance enable; exposes current and next state.
// Load wins over enable; one step per enabled cycle, no backpressure of its own.
module axis_lfsr32
    import axis_pkt_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = 32'hACE1_0001
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              enable,
    output logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] state_next
);

    assign state_next = lfsr_step(state);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= RESET_VAL;
        end else if (load) begin
            state <= seed;
        end else if (enable) begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream traffic source (ramp / LFSR / constant payload); all outputs registered, first beat the cycle after start.
// Holds tdata/tlast under tready backpressure; stop ends generation only at a packet boundary.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int          DWIDTH = 64,
    parameter int          LEN_W  = 16,
    parameter int          CNT_W  = 32,
    parameter int          GAP_W  = 8,
    parameter logic [31:0] SEED   = 32'hACE1_0001
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [CNT_W-1:0]  num_pkts,
    input  logic [GAP_W-1:0]  gap,
    input  logic [DWIDTH-1:0] ramp_start,
    input  logic [DWIDTH-1:0] ramp_inc,
    output logic [DWIDTH-1:0] o_tdata,
    output logic              o_tvalid,
    output logic              o_tlast,
    input  logic              i_tready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam logic [LEN_W-1:0] ONE_L = 1;
    localparam logic [CNT_W-1:0] ONE_C = 1;
    localparam logic [GAP_W-1:0] ONE_G = 1;

    function automatic logic [DWIDTH-1:0] rep32(input logic [31:0] s);
        logic [DWIDTH-1:0] r;
        for (int i = 0; i < DWIDTH; i++) begin
            r[i] = s[i % 32];
        end
        return r;
    endfunction

    state_t            state;
    mode_e             mode_r;
    logic [LEN_W-1:0]  len_m1;
    logic [LEN_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  num_r;
    logic [GAP_W-1:0]  gap_r;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DWIDTH-1:0] base_r;
    logic [DWIDTH-1:0] inc_r;
    logic [DWIDTH-1:0] acc;
    logic              stop_seen;

    logic              accept;
    logic              last_pkt;
    logic              end_req;
    logic [LEN_W-1:0]  len_first;
    logic [DWIDTH-1:0] start_dat;
    logic [DWIDTH-1:0] next_dat;
    logic [DWIDTH-1:0] first_now;
    logic [DWIDTH-1:0] first_gap;

    logic [31:0]       lfsr_q;
    logic [31:0]       lfsr_nx;

    axis_lfsr32 #(
        .RESET_VAL (SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (state == ST_IDLE && start),
        .seed       (SEED),
        .enable     (accept),
        .state      (lfsr_q),
        .state_next (lfsr_nx)
    );

    assign accept    = (state == ST_SEND) && o_tvalid && i_tready;
    assign last_pkt  = (num_r != '0) && (pkt_count + ONE_C == num_r);
    assign end_req   = stop_seen || stop;
    assign len_first = (pkt_len == '0) ? '0 : pkt_len - ONE_L;
    assign start_dat = (mode == MODE_LFSR) ? rep32(SEED) : ramp_start;

    // first_now: opening beat when the next packet follows a tlast handshake
    // directly (LFSR steps on that same edge); first_gap: opening beat after GAP.
    always_comb begin
        next_dat  = base_r;
        first_now = base_r;
        first_gap = base_r;
        case (mode_r)
            MODE_LFSR: begin
                next_dat  = rep32(lfsr_nx);
                first_now = rep32(lfsr_nx);
                first_gap = rep32(lfsr_q);
            end
            MODE_CONST: begin
                next_dat = base_r;
            end
            default: begin
                next_dat = acc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mode_r    <= MODE_RAMP;
            len_m1    <= '0;
            beat_cnt  <= '0;
            num_r     <= '0;
            gap_r     <= '0;
            gap_cnt   <= '0;
            base_r    <= '0;
            inc_r     <= '0;
            acc       <= '0;
            stop_seen <= 1'b0;
            o_tdata   <= '0;
            o_tvalid  <= 1'b0;
            o_tlast   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkt_count <= '0;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && stop) begin
                stop_seen <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SEND;
                        mode_r    <= (mode == MODE_RSVD) ? MODE_RAMP : mode_e'(mode);
                        len_m1    <= len_first;
                        num_r     <= num_pkts;
                        gap_r     <= gap;
                        base_r    <= ramp_start;
                        inc_r     <= ramp_inc;
                        acc       <= ramp_start + ramp_inc;
                        beat_cnt  <= '0;
                        stop_seen <= 1'b0;
                        pkt_count <= '0;
                        busy      <= 1'b1;
                        o_tvalid  <= 1'b1;
                        o_tlast   <= (len_first == '0);
                        o_tdata   <= start_dat;
                    end
                end

                ST_SEND: begin
                    if (accept) begin
                        if (o_tlast) begin
                            pkt_count <= pkt_count + ONE_C;
                            beat_cnt  <= '0;
                            acc       <= base_r + inc_r;
                            if (last_pkt || end_req) begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                o_tvalid <= 1'b0;
                                o_tlast  <= 1'b0;
                            end else if (gap_r != '0) begin
                                state    <= ST_GAP;
                                gap_cnt  <= gap_r;
                                o_tvalid <= 1'b0;
                                o_tlast  <= 1'b0;
                            end else begin
                                o_tdata  <= first_now;
                                o_tlast  <= (len_m1 == '0);
                            end
                        end else begin
                            beat_cnt <= beat_cnt + ONE_L;
                            o_tlast  <= (beat_cnt + ONE_L == len_m1);
                            o_tdata  <= next_dat;
                            acc      <= acc + inc_r;
                        end
                    end
                end

                ST_GAP: begin
                    if (end_req) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (gap_cnt == ONE_G) begin
                        state    <= ST_SEND;
                        o_tvalid <= 1'b1;
                        o_tlast  <= (len_m1 == '0);
                        o_tdata  <= first_gap;
                    end else begin
                        gap_cnt <= gap_cnt - ONE_G;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed vector bench for axis_pkt_gen: per-beat payload/tlast against a reference model,
// handshake stability, gap length, done timing, stop and reset corner cases.
module tb_axis_pkt_gen;

    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] pkt_len;
    logic [31:0] num_pkts;
    logic [7:0]  gap;
    logic [63:0] ramp_start;
    logic [63:0] ramp_inc;
    logic [63:0] o_tdata;
    logic        o_tvalid;
    logic        o_tlast;
    logic        i_tready;
    logic        busy;
    logic        done;
    logic [31:0] pkt_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axis_pkt_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .pkt_len    (pkt_len),
        .num_pkts   (num_pkts),
        .gap        (gap),
        .ramp_start (ramp_start),
        .ramp_inc   (ramp_inc),
        .o_tdata    (o_tdata),
        .o_tvalid   (o_tvalid),
        .o_tlast    (o_tlast),
        .i_tready   (i_tready),
        .busy       (busy),
        .done       (done),
        .pkt_count  (pkt_count)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] len;
        logic [31:0] num;
        logic [7:0]  gap;
        logic [63:0] rs;
        logic [63:0] ri;
        bit          rnd;
        int          stop_beat;
        bit          stop_gap;
        int          exp_beats;
        int          exp_pkts;
        int          exp_idle;
        bit          chk_last;
        logic [63:0] exp_last;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic [1:0] m, int len, int num, int g, logic [63:0] rs,
                                logic [63:0] ri, bit rnd, int sb, bit sg, int eb, int ep,
                                int ei, bit cl, logic [63:0] el);
        vec_t v;
        v.mode = m;          v.len = 16'(len);    v.num = 32'(num);    v.gap = 8'(g);
        v.rs = rs;           v.ri = ri;           v.rnd = rnd;         v.stop_beat = sb;
        v.stop_gap = sg;     v.exp_beats = eb;    v.exp_pkts = ep;     v.exp_idle = ei;
        v.chk_last = cl;     v.exp_last = el;
        return v;
    endfunction

    // Feedback applied term by term from x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) begin
            n[31] = ~n[31];
            n[21] = ~n[21];
            n[1]  = ~n[1];
            n[0]  = ~n[0];
        end
        return n;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_zero(input string nm);
        chk(o_tdata == 64'h0, {nm, "_tdata"}, o_tdata, 64'h0);
        chk(o_tvalid == 1'b0, {nm, "_tvalid"}, 64'(o_tvalid), 64'h0);
        chk(o_tlast == 1'b0, {nm, "_tlast"}, 64'(o_tlast), 64'h0);
        chk(busy == 1'b0, {nm, "_busy"}, 64'(busy), 64'h0);
        chk(done == 1'b0, {nm, "_done"}, 64'(done), 64'h0);
        chk(pkt_count == 32'h0, {nm, "_pkt_count"}, 64'(pkt_count), 64'h0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          beats = 0;
        int          idle  = 0;
        int          len_eff;
        int          j;
        bit          got_done = 1'b0;
        bit          prev_end = 1'b0;
        bit          prev_stall = 1'b0;
        bit          stall_last = 1'b0;
        bit          quiet = 1'b1;
        logic [63:0] stall_dat = '0;
        logic [63:0] last_dat = '0;
        logic [63:0] exp_d;
        logic [31:0] lm = SEED;
        string       nm;

        nm      = $sformatf("v%0d", idx);
        len_eff = (v.len == 16'd0) ? 1 : int'(v.len);

        @(negedge clk);
        mode = v.mode; pkt_len = v.len; num_pkts = v.num; gap = v.gap;
        ramp_start = v.rs; ramp_inc = v.ri; stop = 1'b0; i_tready = 1'b1;
        start = 1'b1;

        for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            if (cyc == 0) begin
                chk(o_tvalid && busy, {nm, "_start_latency"}, {62'h0, busy, o_tvalid}, 64'h3);
            end
            if (done) begin
                got_done = 1'b1;
                chk(prev_end, {nm, "_done_timing"}, 64'(prev_end), 64'h1);
                chk(!busy, {nm, "_busy_fall"}, 64'(busy), 64'h0);
                chk(pkt_count == 32'(v.exp_pkts), {nm, "_pkt_count"}, 64'(pkt_count), 64'(v.exp_pkts));
                chk(beats == v.exp_beats, {nm, "_beats"}, 64'(beats), 64'(v.exp_beats));
                chk(idle == v.exp_idle, {nm, "_idle"}, 64'(idle), 64'(v.exp_idle));
                if (v.chk_last) chk(last_dat == v.exp_last, {nm, "_last_data"}, last_dat, v.exp_last);
            end else begin
                prev_end = 1'b0;
                i_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (prev_stall) begin
                    chk(o_tvalid && o_tdata == stall_dat && o_tlast == stall_last,
                        {nm, "_hold"}, o_tdata, stall_dat);
                end
                if (!o_tvalid) begin
                    if (beats > 0) idle++;
                    if (v.stop_gap && beats > 0) begin
                        stop = 1'b1;
                        prev_end = 1'b1;
                    end
                end else begin
                    if (v.stop_beat == beats) stop = 1'b1;
                    if (i_tready) begin
                        j = beats % len_eff;
                        if (v.mode == 2'd1)      exp_d = {lm, lm};
                        else if (v.mode == 2'd2) exp_d = v.rs;
                        else                     exp_d = v.rs + 64'(j) * v.ri;
                        chk(o_tdata == exp_d, $sformatf("%s_tdata_b%0d", nm, beats), o_tdata, exp_d);
                        chk(o_tlast == (j == len_eff - 1), $sformatf("%s_tlast_b%0d", nm, beats),
                            64'(o_tlast), 64'(j == len_eff - 1));
                        lm = ref_step(lm);
                        last_dat = o_tdata;
                        beats++;
                        if (beats == v.exp_beats) prev_end = 1'b1;
                    end
                end
                prev_stall = o_tvalid && !i_tready;
                stall_dat  = o_tdata;
                stall_last = o_tlast;
            end
        end
        chk(got_done, {nm, "_timeout"}, 64'(got_done), 64'h1);
        stop = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_tvalid) quiet = 1'b0;
        end
        chk(quiet, {nm, "_quiet_after_done"}, 64'(quiet), 64'h1);
    endtask

    initial begin
        //             mode len num gap rs                     ri     rnd stopb sg beats pkts idle chk last
        vecs[0]  = mk(2'd0, 4, 2, 0, 64'd10,                 64'd3, 0, -1,   0, 8,  2, 0, 1, 64'd19);
        vecs[1]  = mk(2'd0, 4, 2, 3, 64'd10,                 64'd3, 0, -1,   0, 8,  2, 3, 1, 64'd19);
        vecs[2]  = mk(2'd0, 4, 2, 0, 64'd10,                 64'd3, 1, -1,   0, 8,  2, 0, 1, 64'd19);
        vecs[3]  = mk(2'd1, 8, 3, 0, 64'd0,                  64'd0, 0, -1,   0, 24, 3, 0, 0, 64'd0);
        vecs[4]  = mk(2'd1, 8, 3, 0, 64'd0,                  64'd0, 0, -1,   0, 24, 3, 0, 0, 64'd0);
        vecs[5]  = mk(2'd2, 0, 3, 1, 64'h55,                 64'd9, 0, -1,   0, 3,  3, 2, 1, 64'h55);
        vecs[6]  = mk(2'd3, 3, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0, -1,  0, 3,  1, 0, 1, 64'h0);
        vecs[7]  = mk(2'd0, 4, 0, 0, 64'd0,                  64'd1, 0, 17,   0, 20, 5, 0, 1, 64'd3);
        vecs[8]  = mk(2'd0, 2, 0, 5, 64'd7,                  64'd1, 0, -1,   1, 2,  1, 1, 1, 64'd8);
        vecs[9]  = mk(2'd1, 5, 2, 2, 64'd0,                  64'd0, 1, -1,   0, 10, 2, 2, 0, 64'd0);
        vecs[10] = mk(2'd0, 3, 1, 0, 64'd100,                64'd1, 0, -1,   0, 3,  1, 0, 1, 64'd102);

        reset_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; pkt_len = '0;
        num_pkts = '0; gap = '0; ramp_start = '0; ramp_inc = '0; i_tready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset asserted while a packet is mid-flight.
        @(negedge clk);
        mode = 2'd0; pkt_len = 16'd8; num_pkts = 32'd1; gap = 8'd0;
        ramp_start = 64'd100; ramp_inc = 64'd1; i_tready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk(o_tvalid && o_tdata == 64'd102, "midpkt_before_reset", o_tdata, 64'd102);
        reset_n = 1'b0;
        @(negedge clk);
        check_zero("midpkt_reset");
        reset_n = 1'b1;
        run_vec(vecs[10], 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
